// File: rtl/cache_data_array.sv
// Set-associative cache data store with a byte-enabled core word port and
// a line engine that refills or evicts whole lines over valid/ready handshakes.
module cache_data_array #(
  parameter int DATA_WIDTH    = 32,
  parameter int DATA_BYTE_NUM = DATA_WIDTH / 8,
  parameter int SET_BITS      = 5,
  parameter int WORD_BITS     = 2,
  parameter int WAY_BITS      = 1,
  parameter int WAY_NUM       = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_en,
  input  logic [WAY_BITS-1:0]      rd_way,
  input  logic [SET_BITS-1:0]      rd_set,
  input  logic [WORD_BITS-1:0]     rd_word,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_valid,
  input  logic                     wr_en,
  input  logic [WAY_BITS-1:0]      wr_way,
  input  logic [SET_BITS-1:0]      wr_set,
  input  logic [WORD_BITS-1:0]     wr_word,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic [DATA_BYTE_NUM-1:0] wr_byte_en,
  output logic                     wr_ready,
  input  logic                     fill_start,
  input  logic [WAY_BITS-1:0]      fill_way,
  input  logic [SET_BITS-1:0]      fill_set,
  input  logic                     fill_valid,
  input  logic [DATA_WIDTH-1:0]    fill_data,
  output logic                     fill_ready,
  output logic                     fill_done,
  input  logic                     evict_start,
  input  logic [WAY_BITS-1:0]      evict_way,
  input  logic [SET_BITS-1:0]      evict_set,
  output logic                     evict_valid,
  output logic [DATA_WIDTH-1:0]    evict_data,
  input  logic                     evict_ready,
  output logic                     evict_done,
  output logic                     busy
);

  localparam int IDX_W = WAY_BITS + SET_BITS + WORD_BITS;
  localparam int DEPTH = WAY_NUM << (SET_BITS + WORD_BITS);
  localparam logic [WORD_BITS-1:0] LAST_WORD = {WORD_BITS{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    EVICT = 2'd2
  } state_t;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0]    old_word,
    input logic [DATA_WIDTH-1:0]    new_word,
    input logic [DATA_BYTE_NUM-1:0] byte_en
  );
    logic [DATA_WIDTH-1:0] result;
    result = old_word;
    for (int i = 0; i < DATA_BYTE_NUM; i++) begin
      if (byte_en[i]) begin
        result[i*8 +: 8] = new_word[i*8 +: 8];
      end else begin
        result[i*8 +: 8] = old_word[i*8 +: 8];
      end
    end
    return result;
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  state_t                state_r, state_s;
  logic [WAY_BITS-1:0]   line_way_r;
  logic [SET_BITS-1:0]   line_set_r;
  logic [WORD_BITS-1:0]  cnt_r;
  logic [DATA_WIDTH-1:0] rd_data_r, evict_data_r;
  logic                  rd_valid_r, wr_ready_r, fill_ready_r, fill_done_r;
  logic                  evict_valid_r, evict_done_r, busy_r;

  logic                  core_rd_s, core_wr_s, fill_hs_s, evict_hs_s, last_s;
  logic [WORD_BITS-1:0]  cnt_inc_s;
  logic [IDX_W-1:0]      rd_idx_s, wr_idx_s, evict_idx_s, mem_widx_s;
  logic [DATA_WIDTH-1:0] wr_merged_s, rd_word_s, evict_word_s, mem_wdata_s;
  logic                  mem_we_s;

  // Next-state, handshakes, write-port mux and read-side forwarding
  always_comb begin
    state_s      = state_r;
    core_rd_s    = (state_r == IDLE) && rd_en;
    core_wr_s    = (state_r == IDLE) && wr_en;
    fill_hs_s    = (state_r == FILL) && fill_valid && fill_ready_r;
    evict_hs_s   = (state_r == EVICT) && evict_valid_r && evict_ready;
    last_s       = (cnt_r == LAST_WORD);
    cnt_inc_s    = cnt_r + WORD_BITS'(1'b1);
    rd_idx_s     = {rd_way, rd_set, rd_word};
    wr_idx_s     = {wr_way, wr_set, wr_word};
    wr_merged_s  = merge_bytes(mem_r[wr_idx_s], wr_data, wr_byte_en);
    mem_we_s     = 1'b0;
    mem_widx_s   = wr_idx_s;
    mem_wdata_s  = wr_merged_s;

    if (core_wr_s && (wr_idx_s == rd_idx_s)) begin
      rd_word_s = wr_merged_s;
    end else begin
      rd_word_s = mem_r[rd_idx_s];
    end

    // The evict pointer looks one word ahead so each handshake presents the next word with no bubble
    if (state_r == IDLE) begin
      evict_idx_s = {evict_way, evict_set, {WORD_BITS{1'b0}}};
    end else begin
      evict_idx_s = {line_way_r, line_set_r, cnt_inc_s};
    end
    evict_word_s = mem_r[evict_idx_s];

    if (rst) begin
      mem_we_s = 1'b0;
    end else if (core_wr_s) begin
      mem_we_s = 1'b1;
    end else if (fill_hs_s) begin
      mem_we_s    = 1'b1;
      mem_widx_s  = {line_way_r, line_set_r, cnt_r};
      mem_wdata_s = fill_data;
    end else begin
      mem_we_s = 1'b0;
    end

    case (state_r)
      IDLE: begin
        if (evict_start) begin
          state_s = EVICT;
        end else if (fill_start) begin
          state_s = FILL;
        end else begin
          state_s = IDLE;
        end
      end
      FILL: begin
        if (fill_hs_s && last_s) begin
          state_s = IDLE;
        end else begin
          state_s = FILL;
        end
      end
      EVICT: begin
        if (evict_hs_s && last_s) begin
          state_s = IDLE;
        end else begin
          state_s = EVICT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Data array write port; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_widx_s] <= mem_wdata_s;
    end
  end

  // State, line latch, word counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      line_way_r    <= {WAY_BITS{1'b0}};
      line_set_r    <= {SET_BITS{1'b0}};
      cnt_r         <= {WORD_BITS{1'b0}};
      rd_data_r     <= {DATA_WIDTH{1'b0}};
      rd_valid_r    <= 1'b0;
      wr_ready_r    <= 1'b0;
      fill_ready_r  <= 1'b0;
      fill_done_r   <= 1'b0;
      evict_valid_r <= 1'b0;
      evict_data_r  <= {DATA_WIDTH{1'b0}};
      evict_done_r  <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      busy_r       <= (state_s != IDLE);
      fill_ready_r <= (state_s == FILL);
      rd_valid_r   <= core_rd_s;
      wr_ready_r   <= core_wr_s;
      fill_done_r  <= fill_hs_s && last_s;
      evict_done_r <= evict_hs_s && last_s;
      if (core_rd_s) begin
        rd_data_r <= rd_word_s;
      end
      case (state_r)
        IDLE: begin
          if (evict_start) begin
            line_way_r    <= evict_way;
            line_set_r    <= evict_set;
            cnt_r         <= {WORD_BITS{1'b0}};
            evict_valid_r <= 1'b1;
            evict_data_r  <= evict_word_s;
          end else if (fill_start) begin
            line_way_r <= fill_way;
            line_set_r <= fill_set;
            cnt_r      <= {WORD_BITS{1'b0}};
          end
        end
        FILL: begin
          if (fill_hs_s) begin
            cnt_r <= cnt_inc_s;
          end
        end
        EVICT: begin
          if (evict_hs_s) begin
            cnt_r <= cnt_inc_s;
            if (last_s) begin
              evict_valid_r <= 1'b0;
            end else begin
              evict_data_r <= evict_word_s;
            end
          end
        end
        default: cnt_r <= {WORD_BITS{1'b0}};
      endcase
    end
  end

  assign rd_data     = rd_data_r;
  assign rd_valid    = rd_valid_r;
  assign wr_ready    = wr_ready_r;
  assign fill_ready  = fill_ready_r;
  assign fill_done   = fill_done_r;
  assign evict_valid = evict_valid_r;
  assign evict_data  = evict_data_r;
  assign evict_done  = evict_done_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_cache_data_array.sv
// Bench for cache_data_array: a line-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cache_data_array;

  localparam int WORDS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic        rd_way = 1'b0, wr_way = 1'b0;
  logic [4:0]  rd_set = 5'd0, wr_set = 5'd0;
  logic [1:0]  rd_word = 2'd0, wr_word = 2'd0;
  logic [31:0] wr_data = 32'd0;
  logic [3:0]  wr_byte_en = 4'd0;
  logic        fill_start = 1'b0, fill_way = 1'b0, fill_valid = 1'b0;
  logic [4:0]  fill_set = 5'd0;
  logic [31:0] fill_data = 32'd0;
  logic        evict_start = 1'b0, evict_way = 1'b0, evict_ready = 1'b0;
  logic [4:0]  evict_set = 5'd0;
  logic [31:0] rd_data, evict_data;
  logic        rd_valid, wr_ready, fill_ready, fill_done, evict_valid, evict_done, busy;

  cache_data_array dut (
    .clk(clk), .rst(rst),
    .rd_en(rd_en), .rd_way(rd_way), .rd_set(rd_set), .rd_word(rd_word),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_way(wr_way), .wr_set(wr_set), .wr_word(wr_word),
    .wr_data(wr_data), .wr_byte_en(wr_byte_en), .wr_ready(wr_ready),
    .fill_start(fill_start), .fill_way(fill_way), .fill_set(fill_set),
    .fill_valid(fill_valid), .fill_data(fill_data), .fill_ready(fill_ready),
    .fill_done(fill_done),
    .evict_start(evict_start), .evict_way(evict_way), .evict_set(evict_set),
    .evict_valid(evict_valid), .evict_data(evict_data), .evict_ready(evict_ready),
    .evict_done(evict_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 refill, 2 readout; the line is a plain 3-D array
  logic [31:0] mem_m [2][32][WORDS];
  int          mode, pos, lway, lset;
  logic [31:0] e_rd_data, e_evict_data;
  logic        e_rd_valid, e_wr_ready, e_fill_ready, e_fill_done;
  logic        e_evict_valid, e_evict_done, e_busy;

  task automatic model_reset();
    mode = 0; pos = 0;
    e_rd_data = 32'd0; e_evict_data = 32'd0;
    e_rd_valid = 1'b0; e_wr_ready = 1'b0; e_fill_ready = 1'b0; e_fill_done = 1'b0;
    e_evict_valid = 1'b0; e_evict_done = 1'b0; e_busy = 1'b0;
  endtask

  task automatic model_step();
    e_rd_valid = 1'b0; e_wr_ready = 1'b0; e_fill_done = 1'b0; e_evict_done = 1'b0;
    case (mode)
      0: begin
        if (wr_en) begin
          for (int b = 0; b < 4; b++)
            if (wr_byte_en[b]) mem_m[wr_way][wr_set][wr_word][8*b +: 8] = wr_data[8*b +: 8];
          e_wr_ready = 1'b1;
        end
        if (rd_en) begin
          e_rd_data  = mem_m[rd_way][rd_set][rd_word];
          e_rd_valid = 1'b1;
        end
        if (evict_start) begin
          mode = 2; lway = int'(evict_way); lset = int'(evict_set); pos = 0;
          e_evict_valid = 1'b1;
          e_evict_data  = mem_m[lway][lset][0];
        end else if (fill_start) begin
          mode = 1; lway = int'(fill_way); lset = int'(fill_set); pos = 0;
        end
      end
      1: if (fill_valid) begin
        mem_m[lway][lset][pos] = fill_data;
        pos++;
        if (pos == WORDS) begin mode = 0; pos = 0; e_fill_done = 1'b1; end
      end
      2: if (evict_ready) begin
        pos++;
        if (pos == WORDS) begin
          mode = 0; pos = 0; e_evict_valid = 1'b0; e_evict_done = 1'b1;
        end else begin
          e_evict_data = mem_m[lway][lset][pos];
        end
      end
      default: mode = 0;
    endcase
    e_busy       = (mode != 0);
    e_fill_ready = (mode == 1);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Compare every output against the model on every falling edge
  initial begin
    forever begin
      @(negedge clk);
      chk32("rd_data", rd_data, e_rd_data);
      chk1("rd_valid", rd_valid, e_rd_valid);
      chk1("wr_ready", wr_ready, e_wr_ready);
      chk1("fill_ready", fill_ready, e_fill_ready);
      chk1("fill_done", fill_done, e_fill_done);
      chk1("evict_valid", evict_valid, e_evict_valid);
      chk32("evict_data", evict_data, e_evict_data);
      chk1("evict_done", evict_done, e_evict_done);
      chk1("busy", busy, e_busy);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic w, input logic [4:0] s, input logic [1:0] d,
                        input logic [31:0] data, input logic [3:0] be);
    wr_en = 1'b1; wr_way = w; wr_set = s; wr_word = d; wr_data = data; wr_byte_en = be;
  endtask

  task automatic set_rd(input logic w, input logic [4:0] s, input logic [1:0] d);
    rd_en = 1'b1; rd_way = w; rd_set = s; rd_word = d;
  endtask

  initial begin
    #12;
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_fill_ready", fill_ready, 1'b0);
    chk32("reset_rd_data", rd_data, 32'd0);
    chk32("reset_evict_data", evict_data, 32'd0);
    #10 rst = 1'b0;
    cyc();

    // Give every word a known value
    for (int i = 0; i < 256; i++) begin
      set_wr(1'b0, 5'd0, 2'd0, $urandom, 4'hF);
      {wr_way, wr_set, wr_word} = 8'(i);
      cyc();
    end
    wr_en = 1'b0;

    // Byte-enabled writes then read
    set_wr(1'b0, 5'd3, 2'd1, 32'hDEADBEEF, 4'b1111); cyc();
    chk1("wr_ready_first", wr_ready, 1'b1);
    set_wr(1'b0, 5'd3, 2'd1, 32'h000000AA, 4'b0001); cyc();
    chk1("wr_ready_second", wr_ready, 1'b1);
    wr_en = 1'b0; set_rd(1'b0, 5'd3, 2'd1); cyc(); rd_en = 1'b0;
    chk1("rd_valid_latency", rd_valid, 1'b1);
    chk32("rd_byte_merge", rd_data, 32'hDEADBEAA);
    cyc();
    chk1("rd_valid_pulse", rd_valid, 1'b0);
    chk32("rd_data_hold", rd_data, 32'hDEADBEAA);

    // Same-cycle write/read forwarding
    set_wr(1'b1, 5'd2, 2'd3, 32'hAAAAAAAA, 4'hF); cyc();
    set_wr(1'b1, 5'd2, 2'd3, 32'h11223344, 4'b1100); set_rd(1'b1, 5'd2, 2'd3); cyc();
    wr_en = 1'b0; rd_en = 1'b0;
    chk32("rd_forward", rd_data, 32'h1122AAAA);

    // Refill with gaps
    fill_way = 1'b1; fill_set = 5'd7; fill_start = 1'b1; cyc(); fill_start = 1'b0;
    chk1("fill_busy", busy, 1'b1);
    chk1("fill_ready_on", fill_ready, 1'b1);
    for (int k = 0; k < 4; k++) begin
      fill_data = 32'((k + 1) * 16); fill_valid = 1'b1; cyc(); fill_valid = 1'b0;
      if (k < 3) begin cyc(); chk1("fill_gap_busy", busy, 1'b1); end
    end
    chk1("fill_done_pulse", fill_done, 1'b1);
    chk1("fill_busy_end", busy, 1'b0);
    chk1("fill_ready_end", fill_ready, 1'b0);
    cyc();
    chk1("fill_done_once", fill_done, 1'b0);
    for (int k = 0; k < 4; k++) begin
      set_rd(1'b1, 5'd7, 2'(k)); cyc();
      chk32("fill_readback", rd_data, 32'((k + 1) * 16));
    end
    rd_en = 1'b0;

    // Readout with a stall
    evict_way = 1'b1; evict_set = 5'd7; evict_ready = 1'b0; evict_start = 1'b1; cyc();
    evict_start = 1'b0;
    chk1("evict_valid_rise", evict_valid, 1'b1);
    chk32("evict_word0", evict_data, 32'h10);
    repeat (3) begin cyc(); chk32("evict_stall_data", evict_data, 32'h10); end
    evict_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin cyc(); chk32("evict_stream", evict_data, 32'((k + 1) * 16)); end
    cyc(); evict_ready = 1'b0;
    chk1("evict_valid_end", evict_valid, 1'b0);
    chk1("evict_done_pulse", evict_done, 1'b1);
    cyc();
    chk1("evict_done_once", evict_done, 1'b0);

    // Both starts together; core write while busy
    evict_way = 1'b0; evict_set = 5'd3; fill_way = 1'b0; fill_set = 5'd4;
    evict_start = 1'b1; fill_start = 1'b1; cyc(); evict_start = 1'b0; fill_start = 1'b0;
    chk1("prio_busy", busy, 1'b1);
    chk1("prio_no_fill", fill_ready, 1'b0);
    chk1("prio_evict", evict_valid, 1'b1);
    set_wr(1'b0, 5'd3, 2'd1, 32'h12345678, 4'hF); cyc(); wr_en = 1'b0;
    chk1("busy_no_wr_ready", wr_ready, 1'b0);
    evict_ready = 1'b1; repeat (4) cyc(); evict_ready = 1'b0;
    chk1("prio_evict_done", evict_done, 1'b1);
    cyc();
    chk1("prio_fill_dropped", fill_ready, 1'b0);
    set_rd(1'b0, 5'd3, 2'd1); cyc(); rd_en = 1'b0;
    chk32("busy_no_write", rd_data, 32'hDEADBEAA);

    // Reset in the middle of a refill
    for (int d = 0; d < 4; d++) begin set_wr(1'b0, 5'd5, 2'(d), 32'hC0DE0000 + 32'(d), 4'hF); cyc(); end
    wr_en = 1'b0;
    fill_way = 1'b0; fill_set = 5'd5; fill_start = 1'b1; cyc(); fill_start = 1'b0;
    fill_valid = 1'b1; fill_data = 32'h55; cyc();
    fill_data = 32'h66; cyc(); fill_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_fill_ready", fill_ready, 1'b0);
    chk32("rst_rd_data", rd_data, 32'd0);
    @(posedge clk); #2 rst = 1'b0;
    cyc();
    chk1("rst_no_fill_done", fill_done, 1'b0);
    for (int d = 0; d < 4; d++) begin
      set_rd(1'b0, 5'd5, 2'(d)); cyc();
      chk32("rst_partial_line", rd_data, (d == 0) ? 32'h55 : (d == 1) ? 32'h66 : 32'hC0DE0000 + 32'(d));
    end
    rd_en = 1'b0;

    // Randomized traffic over a small address window to provoke collisions
    for (int n = 0; n < 3000; n++) begin
      rd_en = 1'($urandom_range(0, 1));
      set_rd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      rd_en = 1'($urandom_range(0, 1));
      set_wr(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             $urandom, 4'($urandom_range(0, 15)));
      wr_en = 1'($urandom_range(0, 1));
      fill_start  = ($urandom_range(0, 19) == 0);
      evict_start = ($urandom_range(0, 19) == 0);
      fill_way  = 1'($urandom_range(0, 1)); fill_set  = 5'($urandom_range(0, 3));
      evict_way = 1'($urandom_range(0, 1)); evict_set = 5'($urandom_range(0, 3));
      fill_valid  = 1'($urandom_range(0, 1));
      fill_data   = $urandom;
      evict_ready = 1'($urandom_range(0, 1));
      if (fill_start || evict_start) wr_en = 1'b0;
      cyc();
    end
    rd_en = 1'b0; wr_en = 1'b0; fill_start = 1'b0; evict_start = 1'b0;
    fill_valid = 1'b1; evict_ready = 1'b1;
    repeat (8) cyc();
    chk1("drain_idle", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
